// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants for the seven-segment MMIO controller
// Contents: register word addresses, CTRL bit indices, blank pattern,
//           character codes, STATUS field offsets, circular index helper.
package ssd_pkg;

   // Register word addresses (MSG_PUSH write and STATUS read share address 3)
   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_DIRECT = 3'd1;
   localparam logic [2:0] ADDR_PERIOD = 3'd2;
   localparam logic [2:0] ADDR_MSG    = 3'd3;
   localparam logic [2:0] ADDR_CLEAR  = 3'd4;

   // CTRL bit indices
   localparam int CTRL_CHAR   = 0;
   localparam int CTRL_SCROLL = 1;
   localparam int CTRL_BLANK  = 2;

   // Segments are active low, so all ones turns every digit off
   localparam logic [31:0] SSD_BLANK = 32'hFFFF_FFFF;

   // STATUS field offsets
   localparam int STAT_LEN_LSB = 0;
   localparam int STAT_POS_LSB = 8;
   localparam int STAT_OVF_BIT = 16;

   // Character codes understood by the downstream driver
   typedef enum logic [5:0] {
      CH_0    = 6'h00, CH_1 = 6'h01, CH_2 = 6'h02, CH_3 = 6'h03,
      CH_4    = 6'h04, CH_5 = 6'h05, CH_6 = 6'h06, CH_7 = 6'h07,
      CH_8    = 6'h08, CH_9 = 6'h09, CH_A = 6'h0A, CH_B = 6'h0B,
      CH_C    = 6'h0C, CH_D = 6'h0D, CH_E = 6'h0E, CH_F = 6'h0F,
      CH_H_LC = 6'h11, CH_L = 6'h15, CH_O_LC = 6'h18
   } ssd_char_t;

   // (sum mod len) for sum < len + 4; len is not a power of two in general,
   // so a few conditional subtractions replace a real divider.
   function automatic logic [5:0] wrap_index(input logic [6:0] sum, input logic [5:0] len);
      logic [6:0] v;
      v = sum;
      for (int i = 0; i < 4; i++) begin
         if (len != 6'd0 && v >= {1'b0, len})
            v = v - {1'b0, len};
      end
      return v[5:0];
   endfunction

endpackage

// File: rtl/ssd_scroll_timer.sv
// rtl/ssd_scroll_timer.sv - programmable prescaler producing the scroll tick
// Ports: clk, rst_n (sync, active low); en = count enable (scroll on and
//        period nonzero); restart = zero the prescaler this cycle;
//        period = tick interval in cycles; tick = one-cycle pulse.
module ssd_scroll_timer #(
   parameter int PERIOD_W = 26
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                restart,
   input  logic [PERIOD_W-1:0] period,
   output logic                tick
);

   logic [PERIOD_W-1:0] cnt;
   logic                at_end;

   assign at_end = (cnt == period - PERIOD_W'(1));
   // A restart discards the interval in progress, so it also masks the tick
   assign tick   = en && !restart && at_end;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (restart)
         cnt <= '0;
      else if (en)
         cnt <= at_end ? '0 : cnt + PERIOD_W'(1);
   end

endmodule

// File: rtl/ssd_mmio_ctrl.sv
// rtl/ssd_mmio_ctrl.sv - register block and text scroller feeding the segment driver
// Ports: clk, rst_n (sync, active low); addr/wr_en/rd_en/wdata = CPU bus,
//        rdata = registered read data; ssd_bits/ssd_char_mode = driver inputs.
module ssd_mmio_ctrl
   import ssd_pkg::*;
#(
   parameter int MSG_DEPTH = 16,
   parameter int PERIOD_W  = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  addr,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [31:0] ssd_bits,
   output logic        ssd_char_mode
);

   localparam int         IDX_W  = $clog2(MSG_DEPTH);
   localparam logic [5:0] DEPTH6 = 6'(MSG_DEPTH);

   logic [2:0]          ctrl;
   logic [31:0]         direct;
   logic [PERIOD_W-1:0] period;
   logic [5:0]          len;
   logic [5:0]          pos;
   logic                ovf;
   logic [5:0]          msg_buf [MSG_DEPTH];

   logic        push, clear, period_wr, scroll_rise, restart, tick, full;
   logic [31:0] status, rd_mux, scroll_bits, next_bits;
   logic        next_mode;
   logic [5:0]  idx;

   assign push        = wr_en && addr == ADDR_MSG;
   assign clear       = wr_en && addr == ADDR_CLEAR;
   assign period_wr   = wr_en && addr == ADDR_PERIOD;
   // Enabling scroll restarts the message from its first character
   assign scroll_rise = wr_en && addr == ADDR_CTRL && wdata[CTRL_SCROLL] && !ctrl[CTRL_SCROLL];
   assign restart     = scroll_rise || period_wr;
   assign full        = (len == DEPTH6);

   ssd_scroll_timer #(.PERIOD_W(PERIOD_W)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (ctrl[CTRL_SCROLL] && period != '0),
      .restart (restart),
      .period  (period),
      .tick    (tick)
   );

   assign status = {15'b0, ovf, 2'b0, pos, 2'b0, len};

   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_CTRL:   rd_mux = {29'b0, ctrl};
         ADDR_DIRECT: rd_mux = direct;
         ADDR_PERIOD: rd_mux = 32'(period);
         ADDR_MSG:    rd_mux = status;
         default:     rd_mux = '0;
      endcase
   end

   // Digit k (3 = leftmost) shows the character (3 - k) places after pos
   always_comb begin
      scroll_bits = SSD_BLANK;
      idx         = '0;
      for (int k = 0; k < 4; k++) begin
         idx = wrap_index({1'b0, pos} + 7'(3 - k), len);
         scroll_bits[8*k +: 8] = {2'b00, msg_buf[idx[IDX_W-1:0]]};
      end
   end

   always_comb begin
      next_bits = direct;
      next_mode = ctrl[CTRL_CHAR];
      if (ctrl[CTRL_BLANK]) begin
         next_bits = SSD_BLANK;
         next_mode = 1'b0;
      end else if (ctrl[CTRL_SCROLL]) begin
         next_bits = (len != 6'd0) ? scroll_bits : SSD_BLANK;
         next_mode = (len != 6'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl          <= '0;
         direct        <= SSD_BLANK;
         period        <= '0;
         len           <= '0;
         pos           <= '0;
         ovf           <= 1'b0;
         rdata         <= '0;
         ssd_bits      <= SSD_BLANK;
         ssd_char_mode <= 1'b0;
      end else begin
         if (wr_en) begin
            case (addr)
               ADDR_CTRL:   ctrl   <= wdata[2:0];
               ADDR_DIRECT: direct <= wdata;
               ADDR_PERIOD: period <= wdata[PERIOD_W-1:0];
               default:     ;
            endcase
         end

         if (clear) begin
            len <= '0;
            ovf <= 1'b0;
         end else if (push) begin
            if (full) ovf <= 1'b1;
            else      len <= len + 6'd1;
         end

         // Wrap is judged against the length before any same-cycle push
         if (clear || scroll_rise)
            pos <= '0;
         else if (tick && len != 6'd0)
            pos <= (pos + 6'd1 == len) ? 6'd0 : pos + 6'd1;

         if (rd_en) rdata <= rd_mux;

         ssd_bits      <= next_bits;
         ssd_char_mode <= next_mode;
      end
   end

   // Buffer has no reset: len = 0 hides stale entries
   always_ff @(posedge clk) begin
      if (push && !full)
         msg_buf[len[IDX_W-1:0]] <= wdata[5:0];
   end

endmodule

// File: tb/tb_ssd_mmio_ctrl.sv
// tb/tb_ssd_mmio_ctrl.sv - self-checking bench for ssd_mmio_ctrl
module tb_ssd_mmio_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  addr = '0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [31:0] ssd_bits;
   logic        ssd_char_mode;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state
   logic [2:0]  m_ctrl;
   logic [31:0] m_direct;
   int          m_period, m_len, m_pos, m_cnt;
   logic        m_ovf;
   logic [5:0]  m_buf [16];
   logic [31:0] m_rdata, m_bits;
   logic        m_cm;

   ssd_mmio_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .addr          (addr),
      .wr_en         (wr_en),
      .rd_en         (rd_en),
      .wdata         (wdata),
      .rdata         (rdata),
      .ssd_bits      (ssd_bits),
      .ssd_char_mode (ssd_char_mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of the behavioural model, from the pre-edge state and inputs
   task automatic model_step();
      logic [31:0] rv, nb;
      logic        nm, rise, restart, en, tick;
      if (!rst_n) begin
         m_ctrl = 0; m_direct = 32'hFFFF_FFFF; m_period = 0; m_len = 0; m_pos = 0;
         m_cnt = 0; m_ovf = 0; m_rdata = 0; m_bits = 32'hFFFF_FFFF; m_cm = 0;
         return;
      end
      case (addr)
         3'd0:    rv = {29'b0, m_ctrl};
         3'd1:    rv = m_direct;
         3'd2:    rv = m_period;
         3'd3:    rv = (32'(m_ovf) << 16) | (m_pos << 8) | m_len;
         default: rv = 0;
      endcase
      if (m_ctrl[2]) begin
         nb = 32'hFFFF_FFFF; nm = 0;
      end else if (m_ctrl[1] && m_len > 0) begin
         for (int k = 0; k < 4; k++) nb[8*k +: 8] = {2'b00, m_buf[(m_pos + 3 - k) % m_len]};
         nm = 1;
      end else if (m_ctrl[1]) begin
         nb = 32'hFFFF_FFFF; nm = 0;
      end else begin
         nb = m_direct; nm = m_ctrl[0];
      end
      en      = m_ctrl[1] && m_period != 0;
      rise    = wr_en && addr == 3'd0 && wdata[1] && !m_ctrl[1];
      restart = rise || (wr_en && addr == 3'd2);
      tick    = en && !restart && (m_cnt == m_period - 1);
      if (restart)  m_cnt = 0;
      else if (en)  m_cnt = tick ? 0 : m_cnt + 1;
      if ((wr_en && addr == 3'd4) || rise) m_pos = 0;
      else if (tick && m_len > 0)          m_pos = (m_pos + 1) % m_len;
      if (wr_en) begin
         case (addr)
            3'd0: m_ctrl = wdata[2:0];
            3'd1: m_direct = wdata;
            3'd2: m_period = int'(wdata[25:0]);
            3'd3: begin
               if (m_len == 16) m_ovf = 1;
               else begin m_buf[m_len] = wdata[5:0]; m_len++; end
            end
            3'd4: begin m_len = 0; m_ovf = 0; end
            default: ;
         endcase
      end
      if (rd_en) m_rdata = rv;
      m_bits = nb;
      m_cm   = nm;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("model_bits", ssd_bits, m_bits);
      chk("model_mode", {31'b0, ssd_char_mode}, {31'b0, m_cm});
      chk("model_rdata", rdata, m_rdata);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      addr = a; wdata = d; wr_en = 1'b1;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a);
      addr = a; rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      logic [7:0] hello [5];
      hello[0] = 8'h11; hello[1] = 8'h0E; hello[2] = 8'h15; hello[3] = 8'h15; hello[4] = 8'h18;

      // Reset
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      chk("rst_bits", ssd_bits, 32'hFFFF_FFFF);
      chk("rst_mode", {31'b0, ssd_char_mode}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      rd(3'd3);
      chk("rst_status", rdata, 32'd0);

      // Direct mode and readback
      wr(3'd1, 32'h0E0D0C0B);
      wr(3'd0, 32'd1);
      idle(1);
      chk("direct_bits", ssd_bits, 32'h0E0D0C0B);
      chk("direct_mode", {31'b0, ssd_char_mode}, 32'd1);
      rd(3'd1);
      chk("direct_rd", rdata, 32'h0E0D0C0B);
      addr = 3'd1; wdata = 32'h1234_5678; wr_en = 1'b1; rd_en = 1'b1;
      cyc();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("rw_same_old", rdata, 32'h0E0D0C0B);
      rd(3'd1);
      chk("rw_same_new", rdata, 32'h1234_5678);

      // Five-character scroll
      for (int i = 0; i < 5; i++) wr(3'd3, 32'(hello[i]));
      wr(3'd2, 32'd4);
      wr(3'd0, 32'd2);
      idle(1);
      chk("hello_pos0", ssd_bits, 32'h110E1515);
      chk("hello_mode", {31'b0, ssd_char_mode}, 32'd1);
      idle(4);
      chk("hello_pos1", ssd_bits, 32'h0E151518);
      idle(15);
      rd(3'd3);
      chk("hello_wrap", rdata, 32'h0000_0005);

      // Two-character wrap
      wr(3'd4, 32'd0);
      wr(3'd3, 32'h01);
      wr(3'd3, 32'h02);
      wr(3'd0, 32'd0);
      wr(3'd0, 32'd2);
      idle(1);
      chk("two_pos0", ssd_bits, 32'h01020102);
      idle(4);
      chk("two_pos1", ssd_bits, 32'h02010201);

      // Overflow and clear
      wr(3'd4, 32'd0);
      for (int i = 0; i < 17; i++) wr(3'd3, $urandom_range(0, 31));
      rd(3'd3);
      chk("ovf_status", rdata & 32'h0001_003F, 32'h0001_0010);
      wr(3'd4, 32'd0);
      rd(3'd3);
      chk("clear_status", rdata, 32'd0);
      chk("empty_bits", ssd_bits, 32'hFFFF_FFFF);
      chk("empty_mode", {31'b0, ssd_char_mode}, 32'd0);

      // Blank while scrolling
      wr(3'd0, 32'd0);
      for (int i = 0; i < 5; i++) wr(3'd3, 32'(hello[i]));
      wr(3'd2, 32'd4);
      wr(3'd0, 32'd6);
      idle(12);
      chk("blank_bits", ssd_bits, 32'hFFFF_FFFF);
      chk("blank_mode", {31'b0, ssd_char_mode}, 32'd0);
      rd(3'd3);
      chk("blank_pos", rdata, 32'h0000_0305);

      // Reset mid-scroll
      wr(3'd0, 32'd2);
      idle(6);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("midrst_bits", ssd_bits, 32'hFFFF_FFFF);
      chk("midrst_mode", {31'b0, ssd_char_mode}, 32'd0);
      chk("midrst_rdata", rdata, 32'd0);
      rd(3'd3);
      chk("midrst_status", rdata, 32'd0);
      rd(3'd1);
      chk("midrst_direct", rdata, 32'hFFFF_FFFF);

      // Clear on the tick cycle
      for (int i = 0; i < 5; i++) wr(3'd3, 32'(hello[i]));
      wr(3'd2, 32'd4);
      wr(3'd0, 32'd2);
      idle(3);
      wr(3'd4, 32'd0);
      rd(3'd3);
      chk("clear_tick", rdata, 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         logic [2:0] a;
         rst_n = ($urandom_range(0, 299) != 0);
         a     = 3'($urandom_range(0, 7));
         wr_en = ($urandom_range(0, 1) == 1);
         rd_en = ($urandom_range(0, 1) == 1);
         addr  = a;
         case (a)
            3'd0:    wdata = {$urandom} & 32'h7 | (($urandom_range(0, 3) != 0) ? 32'h2 : 32'h0);
            3'd2:    wdata = $urandom_range(0, 5);
            3'd3:    wdata = $urandom;
            3'd4:    begin wdata = $urandom; if ($urandom_range(0, 2) != 0) wr_en = 1'b0; end
            default: wdata = $urandom;
         endcase
         cyc();
      end
      wr_en = 1'b0; rd_en = 1'b0; rst_n = 1'b1;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ssd_mmio_ctrl.md
Name: ssd_mmio_ctrl

Overview:
Memory-mapped peripheral directly upstream of the seven-segment driver. Holds the ssd_bits/ssd_char_mode values the CPU writes over the data bus. Also provides a hardware text-scroll mode that walks a character buffer across the four digits at a programmable rate. Outputs feed the driver's ssd_bits and ssd_char_mode inputs.

Parameters:
MSG_DEPTH, 16, character buffer entries (power of two, 4..32)
PERIOD_W, 26, width of scroll period register/prescaler (2^26 cycles is about 1.34 s at 50 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
addr  in  3  word address of register
wr_en  in  1  write strobe, one cycle per write
rd_en  in  1  read strobe
wdata  in  32  write data
rdata  out  32  read data, valid the cycle after rd_en
ssd_bits  out  32  to driver: 4 bytes, byte0 = rightmost digit, bits[5:0] char code or [6:0] raw segments (1 = off)
ssd_char_mode  out  1  to driver: 1 = char codes, 0 = raw segments

Behaviour:
- Clock is clk. Reset is synchronous and active-low (rst_n sampled on posedge clk only).
- Register map (word addr):
  - 0 CTRL rw: [0] char_mode, [1] scroll_en, [2] blank; other bits read 0.
  - 1 DIRECT rw: 32-bit value shown when not scrolling/blank.
  - 2 PERIOD rw: [PERIOD_W-1:0] scroll period in clk cycles; 0 = scroll frozen.
  - 3 MSG_PUSH w: appends wdata[5:0] at index len, then len++. When len == MSG_DEPTH, the write is dropped and the sticky overflow bit is set.
  - 3 STATUS r: [5:0] len, [13:8] pos, [16] overflow.
  - 4 MSG_CLEAR w (any data): len=0, pos=0, overflow=0.
  - 5-7: writes ignored, reads return 0.
- Reset values: CTRL=0, DIRECT=32'hFFFF_FFFF, PERIOD=0, len=0, pos=0, overflow=0, prescaler=0, rdata=0, ssd_bits=32'hFFFF_FFFF, ssd_char_mode=0.
- Read: rdata registered, 1-cycle latency. rdata holds its last value when rd_en=0. Read and write to the same address in the same cycle returns the old value.
- Prescaler: counts while scroll_en=1 and PERIOD!=0. When it reaches PERIOD-1 it emits a 1-cycle tick and returns to 0.
  - A write to PERIOD zeroes the prescaler.
  - A 0->1 transition of scroll_en zeroes the prescaler and pos.
- On tick with len>0: pos = (pos+1 == len) ? 0 : pos+1. No advance when len=0.
- Scroll digit select: digit k (k=3 leftmost .. 0 rightmost) shows buf[(pos + 3 - k) mod len]. When len<4, indices wrap modulo len.
- Output mux, registered (1 cycle after state change), priority:
  - blank -> ssd_bits=32'hFFFF_FFFF, char_mode=0.
  - scroll_en && len>0 -> byte k = {2'b00, code}, char_mode=1.
  - scroll_en && len==0 -> 32'hFFFF_FFFF, char_mode=0.
  - else -> DIRECT, char_mode=CTRL[0].
- Simultaneous events:
  - MSG_CLEAR and tick in the same cycle: clear wins (pos=0).
  - MSG_PUSH and tick: push updates len first; the tick wraps against the old len.
  - MSG_PUSH when full: buffer unchanged.
- Reset mid-scroll: all state returns to reset values the next clk; buffer contents need not be cleared (len=0 hides them).

Decomposition:
- Package ssd_pkg:
  - register address constants (CTRL..MSG_CLEAR)
  - CTRL bit indices
  - SSD_BLANK = 32'hFFFF_FFFF
  - character code constants (0x00-0x1F, matching the driver's table)
  - STATUS field offsets
- One sub-module: ssd_scroll_timer (prescaler + tick; inputs en, period, restart; output tick).

Test Plan:
- After reset: write DIRECT=32'h0E0D0C0B, CTRL=1 -> next cycle ssd_bits=32'h0E0D0C0B, ssd_char_mode=1. Read addr1 returns same one cycle after rd_en.
- Push 0x11,0x0E,0x15,0x15,0x18 ("hELLo"), PERIOD=4, CTRL=2:
  - pos0 gives ssd_bits=32'h110E1515.
  - After 4 cycles: 32'h0E151518.
  - After 5 ticks, pos wraps to 0.
- Push 2 chars 0x01,0x02, scroll -> 32'h01020102. After a tick -> 32'h02010201.
- Push MSG_DEPTH+1 chars -> STATUS len=16, overflow=1. MSG_CLEAR -> STATUS=0; output becomes 32'hFFFF_FFFF with scroll_en=1.
- CTRL=6 (blank+scroll) -> 32'hFFFF_FFFF, char_mode=0, while pos still advances on ticks.
- Drive rst_n=0 for one cycle mid-scroll -> all outputs and STATUS at reset values on the following cycle. MSG_CLEAR issued on a tick cycle -> pos=0.
